apb_mac_regif26: RTL and testbench
==================================

APB_MAC_REGIF26 -- requirements
Module: apb_mac_regif26

Interface
REQ-001 SHALL have one clock and one reset. The reset is asynchronous and active-high.
REQ-002 SHALL declare the parameter DEPTH26, default 4, as the TX descriptor FIFO depth (power of 2, range 2..16).
REQ-003 SHALL declare the parameter WAIT_MAX26, default 16, as the maximum number of pready-low cycles before an error.
REQ-004 SHALL have the following ports, in this order:
- pclk26  in  1  APB clock.
- preset26  in  1  asynchronous active-high reset.
- psel26  in  1  slave select, driven by the bridge.
- penable26  in  1  APB access phase.
- pwrite26  in  1  1 = write.
- paddr26  in  7  byte address.
- pwdata26  in  32  write data.
- prdata26  out  32  read data.
- pready26  out  1  transfer complete.
- pslverr26  out  1  transfer error, valid when pready26 is high.
- desc_valid26  out  1  FIFO head valid (MAC side).
- desc_data26  out  32  FIFO head word.
- desc_ready26  in  1  MAC pops the head when valid and ready are both high.
- irq26  out  1  level interrupt.

Function
REQ-005 SHALL implement the APB FSM states IDLE, SETUP and ACCESS:
- IDLE -> SETUP when psel26 is high and penable26 is low.
- SETUP -> ACCESS on the next cycle.
- ACCESS -> IDLE when pready26 is high.
- ACCESS stays in ACCESS while pready26 is low.
REQ-006 SHALL drive pready26 high in the first ACCESS cycle for every access except a TXDESC write while the FIFO is full.
REQ-007 SHALL implement this register map (offsets as given; all other offsets unmapped):
- 0x00 CTRL  rw  bit0 enable, bit1 irq_en.
- 0x04 STATUS  ro  [4:0] level, bit8 full, bit9 empty.
- 0x08 TXDESC  wo  write pushes pwdata26 into the FIFO.
- 0x0C INT_STAT  w1c  bit0 push_timeout, bit1 drained.
- 0x10 SCRATCH  rw.
REQ-008 SHALL return 0 and assert pslverr26 for accesses to unmapped offsets and for reads of TXDESC. Such writes have no effect.
REQ-009 SHALL drive prdata26 combinationally from the decoded register during ACCESS and hold it at 0 otherwise. Read latency is 2 pclk26 cycles from SETUP.
REQ-010 SHALL push into the FIFO on the ACCESS cycle in which pready26 is high for a TXDESC write, provided the FIFO is not full in that cycle.
REQ-011 SHALL handle a TXDESC write while the FIFO is full as follows:
- hold pready26 low while the FIFO stays full;
- accept the word in the first cycle the FIFO is not full, with pready26 high in that same cycle;
- if the FIFO is still full after WAIT_MAX26 low cycles, complete the transfer with pready26 high and pslverr26 high, discard the word and set INT_STAT.push_timeout.
REQ-012 SHALL allow a pop in the same cycle as a push when the FIFO is not full. The level is unchanged in that case.
REQ-013 SHALL, when full, treat a pop as freeing a slot only in the following cycle (no same-cycle pass-through of a full FIFO).
REQ-014 SHALL assert desc_valid26 only when CTRL.enable is high and the FIFO is non-empty.
REQ-015 SHALL always drive desc_data26 from the FIFO head. A pop while empty or disabled is ignored.
REQ-016 SHALL use wrap-around read and write pointers of log2(DEPTH26)+1 bits. The level is the pointer difference, ranging 0..DEPTH26.
REQ-017 SHALL set INT_STAT.drained on the cycle in which a pop takes the level from 1 to 0.
REQ-018 SHALL clear INT_STAT bits on a write with the corresponding bit set to 1. When a set event and a w1c clear land in the same cycle, the set wins.
REQ-019 SHALL drive irq26 as CTRL.irq_en AND (OR of the INT_STAT bits), registered.
REQ-020 SHALL ignore a de-asserted psel26 during ACCESS: the FSM returns to IDLE with no register side effects.

Reset
REQ-021 SHALL, while preset26 is high, asynchronously force the following:
- FSM to IDLE;
- CTRL, INT_STAT, SCRATCH, pointers and wait counter to 0;
- pready26, pslverr26, prdata26, desc_valid26 and irq26 to 0.
REQ-022 SHALL leave FIFO storage contents unreset. They are unobservable because desc_valid26 is 0.
REQ-023 SHALL abort any transfer in progress when reset asserts mid-transfer; the word is not pushed.

Structure
REQ-024 SHALL place the register offsets, the CTRL/INT_STAT bit positions and the FSM state enum in the shared package apb_mac_regif_pkg26.
REQ-025 SHALL implement the FIFO as the sub-module desc_fifo26, with ports push, pop, data, full, empty and level.

Verification
REQ-026 Reset: assert preset26 mid-ACCESS -> all outputs 0 and STATUS reads 0x200 after release.
REQ-027 Register access: write SCRATCH 0xDEADBEEF, then read -> 0xDEADBEEF, pready26 high in the first ACCESS cycle and pslverr26 0. Read 0x14 -> 0 with pslverr26 1.
REQ-028 FIFO fill and drain: with enable=1 and desc_ready26=0, write 4 TXDESC words -> STATUS 0x104. Raise desc_ready26 -> 4 pops in order, then drained set and irq26 high when irq_en=1.
REQ-029 Full-FIFO stall: with the FIFO full, write TXDESC and pop once 5 cycles later -> pready26 low 6 cycles (5 stall cycles plus the cycle the slot frees, per REQ-013), then high with pslverr26 0, and the word enters at the tail.
REQ-030 Push timeout: with the FIFO full and no pop -> pready26 low for 16 cycles, then pready26=1 and pslverr26=1, push_timeout set, level still 4.
REQ-031 Simultaneous events: push and pop in the same cycle at level 2 -> level stays 2. Write-1-clear of drained in the same cycle as a new drained event -> the bit stays 1.

Source files
------------

// File: rtl/apb_mac_regif26_pkg.sv
// Shared definitions for the APB MAC descriptor register interface:
// register offsets, CTRL / INT_STAT / STATUS bit positions and the APB FSM
// state encoding.
package apb_mac_regif_pkg26;

  localparam logic [6:0] OFF_CTRL     = 7'h00;
  localparam logic [6:0] OFF_STATUS   = 7'h04;
  localparam logic [6:0] OFF_TXDESC   = 7'h08;
  localparam logic [6:0] OFF_INT_STAT = 7'h0C;
  localparam logic [6:0] OFF_SCRATCH  = 7'h10;

  localparam int unsigned CTRL_ENABLE_BIT      = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT      = 1;
  localparam int unsigned INT_PUSH_TIMEOUT_BIT = 0;
  localparam int unsigned INT_DRAINED_BIT      = 1;
  localparam int unsigned STATUS_FULL_BIT      = 8;
  localparam int unsigned STATUS_EMPTY_BIT     = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_mac_regif26_desc_fifo.sv
// TX descriptor FIFO with wrap-around pointers (one extra MSB).
// Ports:
//   clk, rst  clock, asynchronous active-high reset (pointers only)
//   push      write wdata at the tail (ignored when full)
//   pop       drop the head (ignored when empty)
//   wdata     word to push
//   data      current head word
//   full      level == DEPTH
//   empty     level == 0
//   level     wptr - rptr, 0..DEPTH
module desc_fifo26 #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [31:0]              wdata,
  output logic [31:0]              data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [31:0]  mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  // full/empty come from registered pointers, so a pop while full only
  // frees a slot in the following cycle.
  assign level   = wptr - rptr;
  assign full    = (level == DEPTH_L);
  assign empty   = (wptr == rptr);
  assign data    = mem[rptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + ONE_L;
      if (do_pop)  rptr <= rptr + ONE_L;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/apb_mac_regif26.sv
// APB slave register interface feeding a TX descriptor FIFO to a MAC.
// Ports:
//   pclk26, preset26       clock, asynchronous active-high reset
//   psel26 .. pwdata26     APB request side
//   prdata26, pready26,
//   pslverr26              APB response side
//   desc_valid26/data26/
//   ready26                MAC-side FIFO head handshake
//   irq26                  registered level interrupt
module apb_mac_regif26
  import apb_mac_regif_pkg26::*;
#(
  parameter int unsigned DEPTH26    = 4,
  parameter int unsigned WAIT_MAX26 = 16
) (
  input  logic        pclk26,
  input  logic        preset26,
  input  logic        psel26,
  input  logic        penable26,
  input  logic        pwrite26,
  input  logic [6:0]  paddr26,
  input  logic [31:0] pwdata26,
  output logic [31:0] prdata26,
  output logic        pready26,
  output logic        pslverr26,
  output logic        desc_valid26,
  output logic [31:0] desc_data26,
  input  logic        desc_ready26,
  output logic        irq26
);

  localparam int unsigned LW = $clog2(DEPTH26) + 1;
  localparam int unsigned WW = $clog2(WAIT_MAX26 + 1);
  localparam logic [WW-1:0] WAIT_MAX_L = WW'(WAIT_MAX26);
  localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);

  apb_state_t   state;
  apb_state_t   state_nxt;
  logic [1:0]   ctrl;
  logic [1:0]   int_stat;
  logic [1:0]   int_set;
  logic [1:0]   int_clr;
  logic [31:0]  scratch;
  logic [WW-1:0] wait_cnt;
  logic         irq_q;

  logic         fifo_full;
  logic         fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [31:0]  fifo_data;
  logic [31:0]  status_word;

  logic in_access, hit_ctrl, hit_status, hit_txdesc, hit_int, hit_scratch;
  logic unmapped, txdesc_wr, timed_out, stall, err, wr_en, push, pop;

  assign in_access   = (state == ACCESS) && psel26;
  assign hit_ctrl    = (paddr26 == OFF_CTRL);
  assign hit_status  = (paddr26 == OFF_STATUS);
  assign hit_txdesc  = (paddr26 == OFF_TXDESC);
  assign hit_int     = (paddr26 == OFF_INT_STAT);
  assign hit_scratch = (paddr26 == OFF_SCRATCH);
  assign unmapped    = !(hit_ctrl || hit_status || hit_txdesc || hit_int || hit_scratch);

  assign txdesc_wr = in_access && pwrite26 && hit_txdesc;
  assign timed_out = (wait_cnt == WAIT_MAX_L);
  assign stall     = txdesc_wr && fifo_full && !timed_out;
  // A TXDESC write that is still facing a full FIFO when it completes is
  // the timeout case.
  assign err       = unmapped || (hit_txdesc && !pwrite26) || (txdesc_wr && fifo_full);
  assign wr_en     = pready26 && pwrite26;
  assign push      = txdesc_wr && pready26 && !fifo_full;
  assign pop       = desc_valid26 && desc_ready26;

  assign desc_valid26 = ctrl[CTRL_ENABLE_BIT] && !fifo_empty;
  assign desc_data26  = fifo_data;
  assign irq26        = irq_q;

  always_comb begin
    status_word = '0;
    status_word[LW-1:0] = fifo_level;
    status_word[STATUS_FULL_BIT]  = fifo_full;
    status_word[STATUS_EMPTY_BIT] = fifo_empty;
  end

  always_comb begin
    int_set = '0;
    int_set[INT_PUSH_TIMEOUT_BIT] = txdesc_wr && fifo_full && timed_out;
    int_set[INT_DRAINED_BIT]      = pop && !push && (fifo_level == LEVEL_ONE);
    int_clr = (wr_en && hit_int) ? pwdata26[1:0] : 2'b00;
  end

  // FSM state register
  always_ff @(posedge pclk26 or posedge preset26) begin
    if (preset26) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (psel26 && !penable26) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (!psel26 || pready26) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    pready26  = in_access && !stall;
    pslverr26 = pready26 && err;
    prdata26  = '0;
    if (in_access && !pwrite26) begin
      if (hit_ctrl)    prdata26 = {30'b0, ctrl};
      if (hit_status)  prdata26 = status_word;
      if (hit_int)     prdata26 = {30'b0, int_stat};
      if (hit_scratch) prdata26 = scratch;
    end
  end

  always_ff @(posedge pclk26 or posedge preset26) begin
    if (preset26) begin
      ctrl     <= '0;
      int_stat <= '0;
      scratch  <= '0;
      wait_cnt <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_en && hit_ctrl)    ctrl    <= pwdata26[1:0];
      if (wr_en && hit_scratch) scratch <= pwdata26;
      // set beats a simultaneous write-1-clear
      int_stat <= (int_stat & ~int_clr) | int_set;
      wait_cnt <= stall ? (wait_cnt + WW'(1)) : '0;
      irq_q    <= ctrl[CTRL_IRQ_EN_BIT] && (|int_stat);
    end
  end

  desc_fifo26 #(.DEPTH(DEPTH26)) u_fifo (
    .clk   (pclk26),
    .rst   (preset26),
    .push  (push),
    .pop   (pop),
    .wdata (pwdata26),
    .data  (fifo_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_apb_mac_regif26.sv
// Directed bench for apb_mac_regif26 with a descriptor scoreboard.
module tb_apb_mac_regif26;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [6:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic        desc_ready = 1'b0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        desc_valid;
  logic [31:0] desc_data;
  logic        irq;

  int total = 0;
  int bad = 0;
  int pops = 0;
  logic [31:0] sb[$];

  apb_mac_regif26 #(.DEPTH26(4), .WAIT_MAX26(16)) dut (
    .pclk26       (pclk),
    .preset26     (rst),
    .psel26       (psel),
    .penable26    (penable),
    .pwrite26     (pwrite),
    .paddr26      (paddr),
    .pwdata26     (pwdata),
    .prdata26     (prdata),
    .pready26     (pready),
    .pslverr26    (pslverr),
    .desc_valid26 (desc_valid),
    .desc_data26  (desc_data),
    .desc_ready26 (desc_ready),
    .irq26        (irq)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every observed pop must match the oldest accepted word.
  always @(negedge pclk) begin
    #2;
    if (!rst && desc_valid && desc_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL pop_unexpected observed=%h expected=none", desc_data);
      end else begin
        chk("pop_order", desc_data, sb.pop_front());
        pops++;
      end
    end
  end

  // One APB transfer; pop_at >= 0 pulses desc_ready in that ACCESS cycle.
  task automatic apb(input logic wr, input logic [6:0] addr, input logic [31:0] wd,
                     input int pop_at, output logic [31:0] rd, output logic err,
                     output int waits);
    logic done;
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(negedge pclk);
    penable = 1'b1;
    waits = 0; rd = '0; err = 1'b0; done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge pclk);
      if (pop_at >= 0) desc_ready = (i == pop_at);
      #1;
      if (pready) begin
        rd = prdata; err = pslverr; done = 1'b1;
        break;
      end
      waits++;
    end
    chk("apb_done", {31'b0, done}, 32'd1);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    if (pop_at >= 0) desc_ready = 1'b0;
  endtask

  task automatic wr_ok(input string tag, input logic [6:0] addr, input logic [31:0] wd);
    logic [31:0] rd; logic err; int waits;
    apb(1'b1, addr, wd, -1, rd, err, waits);
    chk({tag, "_waits"}, waits, 0);
    chk({tag, "_err"}, {31'b0, err}, 0);
  endtask

  task automatic rd_chk(input string tag, input logic [6:0] addr, input logic [31:0] exp,
                        input logic exp_err);
    logic [31:0] rd; logic err; int waits;
    apb(1'b0, addr, '0, -1, rd, err, waits);
    chk({tag, "_data"}, rd, exp);
    chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    chk({tag, "_waits"}, waits, 0);
  endtask

  task automatic push_ok(input logic [31:0] wd);
    wr_ok("txdesc", 7'h08, wd);
    sb.push_back(wd);
  endtask

  task automatic pop_one();
    @(negedge pclk); desc_ready = 1'b1;
    @(negedge pclk); desc_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd; logic err; int waits;

    // reset state
    repeat (3) @(negedge pclk);
    #1;
    chk("rst_pready", {31'b0, pready}, 0);
    chk("rst_pslverr", {31'b0, pslverr}, 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_valid", {31'b0, desc_valid}, 0);
    chk("rst_irq", {31'b0, irq}, 0);
    @(negedge pclk); rst = 1'b0;

    // reset asserted in the ACCESS cycle of a TXDESC write: nothing pushed
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 7'h08; pwdata = 32'h1234_5678;
    @(negedge pclk); penable = 1'b1;
    @(negedge pclk); #1;
    chk("mid_pready", {31'b0, pready}, 1);
    rst = 1'b1; #1;
    chk("mid_pready_rst", {31'b0, pready}, 0);
    chk("mid_prdata_rst", prdata, 0);
    chk("mid_valid_rst", {31'b0, desc_valid}, 0);
    chk("mid_irq_rst", {31'b0, irq}, 0);
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk); rst = 1'b0;
    rd_chk("status_rst", 7'h04, 32'h200, 1'b0);

    // register access and error decode
    wr_ok("scratch_wr", 7'h10, 32'hDEAD_BEEF);
    rd_chk("scratch_rd", 7'h10, 32'hDEAD_BEEF, 1'b0);
    rd_chk("unmapped_rd", 7'h14, 32'h0, 1'b1);
    rd_chk("txdesc_rd", 7'h08, 32'h0, 1'b1);
    apb(1'b1, 7'h18, 32'hFFFF_FFFF, -1, rd, err, waits);
    chk("unmapped_wr_err", {31'b0, err}, 1);

    // fill with enable and irq_en set, MAC not ready
    wr_ok("ctrl_wr", 7'h00, 32'h3);
    rd_chk("ctrl_rd", 7'h00, 32'h3, 1'b0);
    push_ok(32'hA000_0000);
    push_ok(32'hA000_0001);
    push_ok(32'hA000_0002);
    push_ok(32'hA000_0003);
    rd_chk("status_full", 7'h04, 32'h104, 1'b0);
    chk("head_valid", {31'b0, desc_valid}, 1);
    chk("head_data", desc_data, 32'hA000_0000);

    // full-FIFO stall, one pop in the sixth ACCESS cycle
    apb(1'b1, 7'h08, 32'hB000_0004, 5, rd, err, waits);
    chk("stall_waits", waits, 6);
    chk("stall_err", {31'b0, err}, 0);
    if (!err) sb.push_back(32'hB000_0004);
    rd_chk("status_after_stall", 7'h04, 32'h104, 1'b0);

    // push timeout
    apb(1'b1, 7'h08, 32'hC000_0005, -1, rd, err, waits);
    chk("timeout_waits", waits, 16);
    chk("timeout_err", {31'b0, err}, 1);
    rd_chk("int_timeout", 7'h0C, 32'h1, 1'b0);
    chk("irq_timeout", {31'b0, irq}, 1);
    rd_chk("status_after_timeout", 7'h04, 32'h104, 1'b0);
    wr_ok("int_clr_timeout", 7'h0C, 32'h1);
    rd_chk("int_cleared", 7'h0C, 32'h0, 1'b0);
    chk("irq_cleared", {31'b0, irq}, 0);

    // drain
    @(negedge pclk); desc_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge pclk); #1;
      if (!desc_valid) break;
    end
    @(negedge pclk); desc_ready = 1'b0;
    chk("drain_pops", pops, 5);
    chk("drain_sb_empty", sb.size(), 0);
    rd_chk("int_drained", 7'h0C, 32'h2, 1'b0);
    chk("irq_drained", {31'b0, irq}, 1);
    rd_chk("status_empty", 7'h04, 32'h200, 1'b0);

    // push and pop in the same cycle at level 2
    push_ok(32'hD000_0000);
    push_ok(32'hD000_0001);
    rd_chk("status_lvl2", 7'h04, 32'h002, 1'b0);
    apb(1'b1, 7'h08, 32'hD000_0002, 0, rd, err, waits);
    chk("pushpop_waits", waits, 0);
    chk("pushpop_err", {31'b0, err}, 0);
    sb.push_back(32'hD000_0002);
    rd_chk("status_pushpop", 7'h04, 32'h002, 1'b0);

    // drained event coinciding with its write-1-clear
    pop_one();
    rd_chk("status_lvl1", 7'h04, 32'h001, 1'b0);
    apb(1'b1, 7'h0C, 32'h2, 0, rd, err, waits);
    chk("w1c_race_err", {31'b0, err}, 0);
    rd_chk("int_set_wins", 7'h0C, 32'h2, 1'b0);
    wr_ok("int_clr_drained", 7'h0C, 32'h2);
    rd_chk("int_clr_done", 7'h0C, 32'h0, 1'b0);
    rd_chk("status_empty2", 7'h04, 32'h200, 1'b0);
    chk("total_pops", pops, 8);

    // disabled: head visible on desc_data but not valid, pops ignored
    wr_ok("ctrl_dis", 7'h00, 32'h2);
    push_ok(32'hE000_0000);
    chk("dis_valid", {31'b0, desc_valid}, 0);
    chk("dis_data", desc_data, 32'hE000_0000);
    pop_one();
    rd_chk("status_dis", 7'h04, 32'h001, 1'b0);
    chk("dis_pops", pops, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
